// File: rtl/mem64_arbiter.sv
// Two-port round-robin arbiter in front of the single-port 64-bit data memory,
// with range checking and halt sequencing. Optional counters: MEM64_ARB_STATS_EN.
module mem64_arbiter #(
   parameter logic [63:0] ADDR_MASK = 64'hf8,
   parameter int          CNT_W     = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0,
   input  logic             req1,
   input  logic             we0,
   input  logic             we1,
   input  logic [63:0]      addr0,
   input  logic [63:0]      addr1,
   input  logic [63:0]      wdata0,
   input  logic [63:0]      wdata1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             rvalid0,
   output logic             rvalid1,
   output logic [63:0]      rdata0,
   output logic [63:0]      rdata1,
   output logic             rerr0,
   output logic             rerr1,
   input  logic             halt_in,
   output logic             mem_we,
   output logic             mem_halt,
   output logic [63:0]      mem_addr,
   output logic [63:0]      mem_wdata,
   input  logic [63:0]      mem_rdata,
   output logic [CNT_W-1:0] stat_gnt0,
   output logic [CNT_W-1:0] stat_gnt1,
   output logic [CNT_W-1:0] stat_conflict
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] HALTED = 2'd2;

   logic [1:0]  state_reg;
   logic        rr_reg;
   logic        halt_pend_reg;
   logic        id_reg;
   logic        we_reg;
   logic        oor_reg;
   logic [63:0] addr_reg;
   logic [63:0] wdata_reg;

   logic        both_req;
   logic        any_req;
   logic        win_next;
   logic        start;
   logic        in_access;
   logic [63:0] sel_addr;
   logic [63:0] sel_wdata;
   logic        sel_we;
   logic [1:0]  rvalid_reg;
   logic [1:0]  rerr_reg;
   logic [63:0] rdata_reg [2];

   assign both_req = req0 & req1;
   assign any_req  = req0 | req1;
   // With a single requester it wins outright; on conflict the rr pointer decides.
   assign win_next  = both_req ? rr_reg : req1;
   assign start     = (state_reg == IDLE) && !halt_pend_reg && any_req;
   assign in_access = (state_reg == ACCESS);
   assign sel_addr  = win_next ? addr1  : addr0;
   assign sel_wdata = win_next ? wdata1 : wdata0;
   assign sel_we    = win_next ? we1    : we0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= IDLE;
         rr_reg        <= 1'b0;
         halt_pend_reg <= 1'b0;
         id_reg        <= 1'b0;
         we_reg        <= 1'b0;
         oor_reg       <= 1'b0;
         addr_reg      <= '0;
         wdata_reg     <= '0;
      end else begin
         halt_pend_reg <= halt_pend_reg | halt_in;
         case (state_reg)
            IDLE: begin
               if (halt_pend_reg) begin
                  state_reg <= HALTED;
               end else if (any_req) begin
                  id_reg    <= win_next;
                  we_reg    <= sel_we;
                  addr_reg  <= sel_addr;
                  wdata_reg <= sel_wdata;
                  oor_reg   <= |(sel_addr & ~ADDR_MASK);
                  state_reg <= ACCESS;
               end
            end
            ACCESS: begin
               rr_reg    <= ~id_reg;
               state_reg <= IDLE;
            end
            HALTED:  state_reg <= HALTED;
            default: state_reg <= IDLE;
         endcase
      end
   end

   // Per-port completion registers; rdata holds until that port's next completion.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_port
         logic done;
         assign done = in_access && (id_reg == 1'(gi));
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               rvalid_reg[gi] <= 1'b0;
               rerr_reg[gi]   <= 1'b0;
               rdata_reg[gi]  <= '0;
            end else begin
               rvalid_reg[gi] <= done;
               rerr_reg[gi]   <= done && oor_reg;
               if (done) begin
                  rdata_reg[gi] <= (!we_reg && !oor_reg) ? mem_rdata : 64'd0;
               end
            end
         end
      end
   endgenerate

   assign gnt0      = in_access && !id_reg;
   assign gnt1      = in_access && id_reg;
   assign rvalid0   = rvalid_reg[0];
   assign rvalid1   = rvalid_reg[1];
   assign rerr0     = rerr_reg[0];
   assign rerr1     = rerr_reg[1];
   assign rdata0    = rdata_reg[0];
   assign rdata1    = rdata_reg[1];
   assign mem_we    = in_access && we_reg && !oor_reg;
   assign mem_halt  = (state_reg == HALTED);
   assign mem_addr  = addr_reg;
   assign mem_wdata = wdata_reg;

`ifdef MEM64_ARB_STATS_EN
   logic [CNT_W-1:0] cnt_gnt0_reg;
   logic [CNT_W-1:0] cnt_gnt1_reg;
   logic [CNT_W-1:0] cnt_conflict_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_gnt0_reg     <= '0;
         cnt_gnt1_reg     <= '0;
         cnt_conflict_reg <= '0;
      end else begin
         if (gnt0) cnt_gnt0_reg <= cnt_gnt0_reg + 1'b1;
         if (gnt1) cnt_gnt1_reg <= cnt_gnt1_reg + 1'b1;
         if (start && both_req) cnt_conflict_reg <= cnt_conflict_reg + 1'b1;
      end
   end

   assign stat_gnt0     = cnt_gnt0_reg;
   assign stat_gnt1     = cnt_gnt1_reg;
   assign stat_conflict = cnt_conflict_reg;
`else
   assign stat_gnt0     = '0;
   assign stat_gnt1     = '0;
   assign stat_conflict = '0;
`endif

endmodule

// File: tb/tb_mem64_arbiter.sv
// Directed bench for mem64_arbiter with a small behavioural data memory.
module tb_mem64_arbiter;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
   logic [63:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
   logic        gnt0, gnt1, rvalid0, rvalid1, rerr0, rerr1;
   logic [63:0] rdata0, rdata1;
   logic        halt_in = 1'b0;
   logic        mem_we, mem_halt;
   logic [63:0] mem_addr, mem_wdata, mem_rdata;
   logic [15:0] stat_gnt0, stat_gnt1, stat_conflict;

   logic [63:0] tb_mem [32];
   logic        pre_en = 1'b0;
   logic [4:0]  pre_idx = '0;
   logic [63:0] pre_val = '0;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   assign mem_rdata = tb_mem[mem_addr[7:3]];
   always @(posedge clk) begin
      if (mem_we) tb_mem[mem_addr[7:3]] <= mem_wdata;
      else if (pre_en) tb_mem[pre_idx] <= pre_val;
   end

   mem64_arbiter dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata0(rdata0), .rdata1(rdata1), .rerr0(rerr0), .rerr1(rerr1),
      .halt_in(halt_in), .mem_we(mem_we), .mem_halt(mem_halt),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .stat_gnt0(stat_gnt0), .stat_gnt1(stat_gnt1), .stat_conflict(stat_conflict)
   );

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic preload(input logic [4:0] idx, input logic [63:0] val);
      pre_en = 1'b1; pre_idx = idx; pre_val = val;
      @(posedge clk);
      #1 pre_en = 1'b0;
   endtask

   // Issues one request and reports grant/completion timing and results.
   task automatic run_access(input bit p, input bit we, input logic [63:0] a, input logic [63:0] wd,
                             output int gl, output int vl, output logic [63:0] ga,
                             output logic [63:0] rd, output logic er, output int we_cnt);
      gl = -1; vl = -1; ga = 'x; rd = 'x; er = 1'bx; we_cnt = 0;
      if (p) begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = wd; end
      else   begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = wd; end
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk); #1;
         if (mem_we) we_cnt++;
         if ((p ? gnt1 : gnt0) && gl < 0) begin
            gl = c; ga = mem_addr;
            req0 = 1'b0; req1 = 1'b0;
         end
         if (p ? rvalid1 : rvalid0) begin
            vl = c; rd = p ? rdata1 : rdata0; er = p ? rerr1 : rerr0;
            break;
         end
      end
      req0 = 1'b0; req1 = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_total++;
      if ({gnt0, gnt1, rvalid0, rvalid1, rerr0, rerr1, mem_we, mem_halt} !== 8'd0) begin
         $display("FAIL reset_ctrl: got %b want 00000000", {gnt0, gnt1, rvalid0, rvalid1, rerr0, rerr1, mem_we, mem_halt});
      end else n_pass++;
      n_total++;
      if ({rdata0, rdata1, mem_addr, mem_wdata} !== 256'd0) begin
         $display("FAIL reset_data: rdata0=%h rdata1=%h addr=%h wdata=%h want 0", rdata0, rdata1, mem_addr, mem_wdata);
      end else n_pass++;
      n_total++;
      if ({stat_gnt0, stat_gnt1, stat_conflict} !== 48'd0) begin
         $display("FAIL reset_stats: got %h want 0", {stat_gnt0, stat_gnt1, stat_conflict});
      end else n_pass++;
   endtask

   task automatic test_single_load();
      int gl, vl, wc; logic [63:0] ga, rd; logic er;
      preload(5'd3, 64'h1122334455667788);
      run_access(1'b0, 1'b0, 64'h18, 64'h0, gl, vl, ga, rd, er, wc);
      n_total++;
      if (gl !== 1 || vl !== 2) $display("FAIL load_latency: gnt=%0d rvalid=%0d want 1 2", gl, vl);
      else n_pass++;
      n_total++;
      if (rd !== 64'h1122334455667788 || er !== 1'b0)
         $display("FAIL load_data: rdata=%h rerr=%b want 1122334455667788 0", rd, er);
      else n_pass++;
      $display("load p0 addr=18 rdata=%h rerr=%b", rd, er);
   endtask

   task automatic test_store_load_p1();
      int gl, vl, wc; logic [63:0] ga, rd; logic er;
      run_access(1'b1, 1'b1, 64'h20, 64'hDEADBEEF, gl, vl, ga, rd, er, wc);
      n_total++;
      if (wc !== 1 || ga !== 64'h20) $display("FAIL store_we: we_cycles=%0d addr=%h want 1 20", wc, ga);
      else n_pass++;
      n_total++;
      if (rd !== 64'd0 || er !== 1'b0 || vl !== 2) $display("FAIL store_resp: rdata=%h rerr=%b vl=%0d want 0 0 2", rd, er, vl);
      else n_pass++;
      $display("store p1 addr=20 wdata=deadbeef we_cycles=%0d", wc);
      run_access(1'b1, 1'b0, 64'h20, 64'h0, gl, vl, ga, rd, er, wc);
      n_total++;
      if (rd !== 64'hDEADBEEF || wc !== 0) $display("FAIL store_readback: rdata=%h we_cycles=%0d want deadbeef 0", rd, wc);
      else n_pass++;
      $display("load p1 addr=20 rdata=%h", rd);
   endtask

   task automatic test_range_error();
      int gl, vl, wc; logic [63:0] ga, rd; logic er;
      run_access(1'b0, 1'b0, 64'h100, 64'h0, gl, vl, ga, rd, er, wc);
      n_total++;
      if (er !== 1'b1 || rd !== 64'd0 || wc !== 0 || vl !== 2)
         $display("FAIL range_100: rerr=%b rdata=%h we_cycles=%0d vl=%0d want 1 0 0 2", er, rd, wc, vl);
      else n_pass++;
      run_access(1'b0, 1'b0, 64'h1C, 64'h0, gl, vl, ga, rd, er, wc);
      n_total++;
      if (er !== 1'b1 || rd !== 64'd0 || wc !== 0)
         $display("FAIL range_1c_load: rerr=%b rdata=%h we_cycles=%0d want 1 0 0", er, rd, wc);
      else n_pass++;
      run_access(1'b1, 1'b1, 64'h1C, 64'hBAD0BAD0, gl, vl, ga, rd, er, wc);
      n_total++;
      if (er !== 1'b1 || wc !== 0 || tb_mem[3] !== 64'h1122334455667788)
         $display("FAIL range_1c_store: rerr=%b we_cycles=%0d mem3=%h want 1 0 1122334455667788", er, wc, tb_mem[3]);
      else n_pass++;
      $display("range errors checked: last rerr=%b", er);
   endtask

   task automatic test_contention();
      int seq[$];
      preload(5'd0, 64'hA0A0);
      preload(5'd1, 64'hB1B1);
      do_reset();
      req0 = 1'b1; we0 = 1'b0; addr0 = 64'h00;
      req1 = 1'b1; we1 = 1'b0; addr1 = 64'h08;
      repeat (16) begin
         @(posedge clk); #1;
         if (gnt0) seq.push_back(0);
         if (gnt1) seq.push_back(1);
      end
      req0 = 1'b0; req1 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_total++;
      if (seq.size() !== 8) $display("FAIL contention_count: grants=%0d want 8", seq.size());
      else n_pass++;
      foreach (seq[i]) begin
         n_total++;
         if (seq[i] !== (i % 2)) $display("FAIL contention_order[%0d]: port=%0d want %0d", i, seq[i], i % 2);
         else n_pass++;
      end
      n_total++;
      if (rdata0 !== 64'hA0A0 || rdata1 !== 64'hB1B1)
         $display("FAIL contention_data: rdata0=%h rdata1=%h want a0a0 b1b1", rdata0, rdata1);
      else n_pass++;
`ifdef MEM64_ARB_STATS_EN
      n_total++;
      if (stat_gnt0 !== 16'd4 || stat_gnt1 !== 16'd4 || stat_conflict !== 16'd8)
         $display("FAIL contention_stats: g0=%0d g1=%0d conf=%0d want 4 4 8", stat_gnt0, stat_gnt1, stat_conflict);
      else n_pass++;
`else
      n_total++;
      if (stat_gnt0 !== 16'd0 || stat_gnt1 !== 16'd0 || stat_conflict !== 16'd0)
         $display("FAIL contention_stats: g0=%0d g1=%0d conf=%0d want 0 0 0", stat_gnt0, stat_gnt1, stat_conflict);
      else n_pass++;
`endif
      $display("contention grants=%0d conflicts=%0d", seq.size(), stat_conflict);
   endtask

   task automatic test_halt();
      int g1 = 0;
      int hcnt = 0;
      do_reset();
      req0 = 1'b1; we0 = 1'b0; addr0 = 64'h18;
      req1 = 1'b1; we1 = 1'b0; addr1 = 64'h08;
      @(posedge clk); #1;
      n_total++;
      if (gnt0 !== 1'b1 || gnt1 !== 1'b0) $display("FAIL halt_first_gnt: gnt0=%b gnt1=%b want 1 0", gnt0, gnt1);
      else n_pass++;
      halt_in = 1'b1; req0 = 1'b0;
      @(posedge clk); #1;
      halt_in = 1'b0;
      n_total++;
      if (rvalid0 !== 1'b1 || rdata0 !== 64'h1122334455667788 || mem_halt !== 1'b0)
         $display("FAIL halt_complete: rvalid0=%b rdata0=%h mem_halt=%b want 1 1122334455667788 0", rvalid0, rdata0, mem_halt);
      else n_pass++;
      repeat (6) begin
         @(posedge clk); #1;
         if (gnt1) g1++;
         if (mem_halt) hcnt++;
      end
      req1 = 1'b0;
      n_total++;
      if (g1 !== 0 || hcnt !== 6) $display("FAIL halt_hold: gnt1_count=%0d halt_cycles=%0d want 0 6", g1, hcnt);
      else n_pass++;
      $display("halt sequence: gnt1_count=%0d halt_cycles=%0d", g1, hcnt);
   endtask

   task automatic test_reset_mid_access();
      int gl, vl, wc; logic [63:0] ga, rd; logic er;
      int rv = 0;
      do_reset();
      run_access(1'b0, 1'b0, 64'h18, 64'h0, gl, vl, ga, rd, er, wc);
      req1 = 1'b1; we1 = 1'b0; addr1 = 64'h08;
      @(posedge clk); #1;
      n_total++;
      if (gnt1 !== 1'b1) $display("FAIL midrst_gnt1: gnt1=%b want 1", gnt1);
      else n_pass++;
      reset = 1'b1;
      #1;
      n_total++;
      if ({gnt0, gnt1, rvalid0, rvalid1, mem_we, mem_halt} !== 6'd0 || mem_addr !== 64'd0 || rdata0 !== 64'd0)
         $display("FAIL midrst_outputs: ctrl=%b addr=%h rdata0=%h want 0 0 0",
                  {gnt0, gnt1, rvalid0, rvalid1, mem_we, mem_halt}, mem_addr, rdata0);
      else n_pass++;
      req1 = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         if (rvalid1) rv++;
      end
      n_total++;
      if (rv !== 0) $display("FAIL midrst_no_rvalid: rvalid1_count=%0d want 0", rv);
      else n_pass++;
      req0 = 1'b1; we0 = 1'b0; addr0 = 64'h00;
      req1 = 1'b1; we1 = 1'b0; addr1 = 64'h08;
      @(posedge clk); #1;
      req0 = 1'b0; req1 = 1'b0;
      n_total++;
      if (gnt0 !== 1'b1 || gnt1 !== 1'b0) $display("FAIL midrst_rr: gnt0=%b gnt1=%b want 1 0", gnt0, gnt1);
      else n_pass++;
      repeat (2) @(posedge clk);
      $display("reset mid-access: rvalid1_count=%0d", rv);
   endtask

   initial begin
      test_reset();
      test_single_load();
      test_store_load_p1();
      test_range_error();
      test_contention();
      test_halt();
      test_reset_mid_access();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/mem64_arbiter.md
Name: mem64_arbiter

Overview:
- Shares the single-port 64-bit data memory between two requesters: port 0 is the pipeline MEM stage, port 1 is the loader/debug port.
- Serialises accesses through a small FSM with round-robin fairness and range checking.
- Sequences the end-of-simulation halt so that no access is cut off.
- Sits between the requesters and the data-memory instance, and drives that instance's write_enable, halt, address and write_data pins.

Parameters:
- ADDR_MASK, 64'hf8: legal-address bitmask. Any address with bits set outside the mask is out of range.
- CNT_W, 16: width of the statistics counters (used only with the optional feature).

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- req0 / req1  in  1  access request; held with we/addr/wdata stable until the matching gnt pulse
- we0 / we1  in  1  1 = store, 0 = load
- addr0 / addr1  in  64  byte address; must be 8-byte aligned
- wdata0 / wdata1  in  64  store data
- gnt0 / gnt1  out  1  one-cycle pulse: request accepted, requester may drop req next cycle
- rvalid0 / rvalid1  out  1  one-cycle pulse: completion; read data (or zero) valid
- rdata0 / rdata1  out  64  registered load result; 0 for stores and errors
- rerr0 / rerr1  out  1  qualifies rvalid: address was out of range, no memory access made
- halt_in  in  1  pipeline halt request (level or pulse; sampled each cycle)
- mem_we  out  1  to memory write_enable
- mem_halt  out  1  to memory halt
- mem_addr  out  64  to memory address
- mem_wdata  out  64  to memory write_data
- mem_rdata  in  64  combinational read data from memory
- stat_gnt0 / stat_gnt1 / stat_conflict  out  CNT_W  statistics counters

Behaviour:
- States: IDLE, ACCESS, HALTED.
- Reset values:
  - State IDLE; rr pointer = 0 (port 0 favoured).
  - halt_pend = 0.
  - All outputs 0: gnt*, rvalid*, rerr*, rdata*, mem_we, mem_halt, mem_addr, mem_wdata, counters.
  - Reset asserted mid-ACCESS aborts the access immediately; no rvalid is ever issued for it.
- halt_pend is sticky: set by halt_in in any cycle, cleared only by reset.
- IDLE:
  - If halt_pend is set, go to HALTED. halt_pend has priority over pending requests.
  - Else, if any req is high, choose the winner:
    - Only one req high: that port wins.
    - Both high: the port indicated by the rr pointer wins (conflict).
  - Latch the winner's id, we, addr and wdata; evaluate the range check; go to ACCESS.
  - No req: stay in IDLE.
- ACCESS (exactly 1 cycle):
  - gnt of the winner = 1.
  - mem_addr = latched addr.
  - mem_wdata = latched wdata.
  - mem_we = latched we AND in-range.
  - At the closing edge:
    - rdata of the winner <= (load AND in-range) ? mem_rdata : 0.
    - rerr of the winner <= out-of-range.
    - rvalid of the winner <= 1 for the next cycle.
    - rr pointer <= other port.
    - Next state IDLE.
- Timing:
  - Latency from req sampled in IDLE to gnt: 1 cycle; to rvalid: 2 cycles.
  - Throughput: one access per 2 cycles.
  - The rvalid cycle coincides with the next IDLE arbitration.
  - A requester deasserts req in the rvalid cycle, so it cannot be re-granted spuriously.
- Outside ACCESS, mem_we = 0 and mem_addr/mem_wdata hold their last value.
- Out-of-range is defined as (addr & ~ADDR_MASK) != 0, which also rejects misaligned addresses. Such a request gets gnt and rvalid with rerr = 1; memory is untouched.
- halt_in arriving during ACCESS: the access completes normally (rvalid issued), then IDLE moves to HALTED.
- HALTED: mem_halt = 1 continuously; no further gnt; reqs ignored; leave only via reset.
- rvalid*, rerr* and gnt* are single-cycle pulses; rdata* holds its value until the next completion for that port.

Optional Feature:
- Macro MEM64_ARB_STATS_EN.
- Defined:
  - stat_gnt0 and stat_gnt1 increment on each gnt pulse of their port.
  - stat_conflict increments when IDLE arbitration sees both reqs high.
  - All counters wrap modulo 2^CNT_W and are cleared by reset.
- Undefined:
  - The counters are not instantiated and the stat_* outputs are tied to 0.
  - The port list is unchanged.

Test Plan:
- Single load: memory word 3 = 0x1122334455667788; req0 with we0=0, addr0=0x18 -> gnt0 in the cycle after req, rvalid0 the cycle after that, rdata0=0x1122334455667788, rerr0=0.
- Store then load on port 1: store wdata1=0xDEADBEEF to addr1=0x20, then load 0x20 -> mem_we high for exactly one cycle with mem_addr=0x20; the load returns 0xDEADBEEF.
- Contention: req0 and req1 held high continuously, four accesses each -> grants alternate 0,1,0,1,... starting with port 0 after reset; stat_conflict counts each arbitration that saw both requests (with the macro).
- Range error: load from 0x100, and separately from 0x1C -> rvalid with rerr=1, rdata=0, mem_we never asserted, memory contents unchanged.
- Halt ordering: halt_in pulsed during port 0's ACCESS while req1 is pending -> port 0 completes, port 1 is never granted, mem_halt=1 from the following cycle and stays high.
- Reset mid-ACCESS: assert reset during ACCESS -> all outputs 0 immediately, no rvalid for the aborted access, next arbitration favours port 0.
